// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Phase sequencer for the multi-cycle MIPS-subset CPU. It holds the
//   IF/ID/EXEC/MEM/WB state register and walks each instruction through its
//   phases according to opcode/funct. It stalls on the shared memory
//   handshake and drives the architectural write enables and the PC source
//   select. The per-state datapath mux selects live in the decode LUT, which
//   consumes `state`.
//
// Parameters
//   RESET_STATE  state entered on reset (IF = 3'd0)
//
// Ports
//   clk          in   1   system clock, rising edge
//   reset_n      in   1   asynchronous active-low reset
//   opcode       in   6   IR[31:26]
//   funct        in   6   IR[5:0], only meaningful when opcode == 0
//   zero         in   1   ALU zero flag, valid during EXEC
//   mem_ready    in   1   memory completes the current access this cycle
//   state        out  3   current state: IF=0 ID=1 EXEC=2 MEM=3 WB=4 ERR=7
//                         (doubles as the FSM debug view)
//   mem_req      out  1   memory access request
//   PC_WE, IR_WE, Mem_WE, Reg_WE, A_WE, B_WE
//                out  1   register / memory write enables
//   PCSrc        out  2   0 = PC+4, 1 = jump target, 2 = branch target, 3 = A
//   illegal      out  1   high while in ERR
//   instr_done   out  1   pulse in the final cycle of each instruction
//   cycle_count  out 32   (SEQ_PERF_COUNT_EN only) cycles out of reset and ERR
//   instr_count  out 32   (SEQ_PERF_COUNT_EN only) retired instructions
//
// Build option
//   SEQ_PERF_COUNT_EN  when defined, adds the two performance counters.
//
// Memory handshake
//   mem_req/mem_ready behave as valid/ready. The sequencer holds mem_req high
//   for the whole access. The access completes in the cycle where both are
//   high. mem_ready is ignored whenever mem_req is low.

module multicycle_sequencer #(
  parameter logic [2:0] RESET_STATE = 3'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        PC_WE,
  output logic        IR_WE,
  output logic        Mem_WE,
  output logic        Reg_WE,
  output logic        A_WE,
  output logic        B_WE,
  output logic [1:0]  PCSrc,
  output logic        illegal,
`ifdef SEQ_PERF_COUNT_EN
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
`endif
  output logic        instr_done
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EXEC = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_ERR  = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  state_t state_q, state_d;

  // Instruction classification
  logic is_rtype, is_alu_r, is_jr, is_imm, is_lw, is_sw;
  logic is_j, is_jal, is_beq, is_bne, is_legal;

  always_comb begin
    is_rtype = (opcode == OP_RTYPE);
    is_alu_r = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT));
    is_jr    = is_rtype && (funct == FN_JR);
    is_imm   = (opcode == OP_ADDI) || (opcode == OP_XORI);
    is_lw    = (opcode == OP_LW);
    is_sw    = (opcode == OP_SW);
    is_j     = (opcode == OP_J);
    is_jal   = (opcode == OP_JAL);
    is_beq   = (opcode == OP_BEQ);
    is_bne   = (opcode == OP_BNE);
    is_legal = is_alu_r || is_jr || is_imm || is_lw || is_sw ||
               is_j || is_jal || is_beq || is_bne;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= state_t'(RESET_STATE);
    else          state_q <= state_d;
  end

  assign state = state_q;

  // Next state and Moore-style outputs
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    PC_WE      = 1'b0;
    IR_WE      = 1'b0;
    Mem_WE     = 1'b0;
    Reg_WE     = 1'b0;
    A_WE       = 1'b0;
    B_WE       = 1'b0;
    PCSrc      = 2'd0;
    illegal    = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      ST_IF: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IR_WE   = 1'b1;
          PC_WE   = 1'b1;
          state_d = ST_ID;
        end
      end

      ST_ID: begin
        A_WE = 1'b1;
        B_WE = 1'b1;
        if (!is_legal) begin
          state_d = ST_ERR;
        end else if (is_j) begin
          PC_WE      = 1'b1;
          PCSrc      = 2'd1;
          instr_done = 1'b1;
          state_d    = ST_IF;
        end else begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (is_alu_r || is_imm) begin
          state_d = ST_WB;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else if (is_beq || is_bne) begin
          PC_WE      = is_beq ? zero : !zero;
          PCSrc      = 2'd2;
          instr_done = 1'b1;
          state_d    = ST_IF;
        end else if (is_jr) begin
          PC_WE      = 1'b1;
          PCSrc      = 2'd3;
          instr_done = 1'b1;
          state_d    = ST_IF;
        end else if (is_jal) begin
          Reg_WE     = 1'b1;
          PC_WE      = 1'b1;
          PCSrc      = 2'd1;
          instr_done = 1'b1;
          state_d    = ST_IF;
        end else begin
          // The IR is stable after IF, so this is only reachable if it was
          // corrupted. Trap rather than guess.
          state_d = ST_ERR;
        end
      end

      ST_MEM: begin
        mem_req = 1'b1;
        Mem_WE  = is_sw;
        if (!(is_lw || is_sw)) begin
          state_d = ST_ERR;
        end else if (mem_ready) begin
          if (is_sw) begin
            instr_done = 1'b1;
            state_d    = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end
      end

      ST_WB: begin
        Reg_WE     = 1'b1;
        instr_done = 1'b1;
        state_d    = ST_IF;
      end

      ST_ERR: begin
        illegal = 1'b1;
      end

      // Encodings 5 and 6 are not states; fall into ERR.
      default: begin
        state_d = ST_ERR;
      end
    endcase

    // Reset forces IF asynchronously, and IF would otherwise raise mem_req.
    // Gating here keeps every output quiet for the whole reset window.
    if (!reset_n) begin
      mem_req    = 1'b0;
      PC_WE      = 1'b0;
      IR_WE      = 1'b0;
      Mem_WE     = 1'b0;
      Reg_WE     = 1'b0;
      A_WE       = 1'b0;
      B_WE       = 1'b0;
      PCSrc      = 2'd0;
      illegal    = 1'b0;
      instr_done = 1'b0;
    end
  end

`ifdef SEQ_PERF_COUNT_EN
  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_count <= 32'd0;
      instr_count <= 32'd0;
    end else begin
      if (state_q != ST_ERR) cycle_count <= cycle_count + 32'd1;
      if (instr_done)        instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
module tb_multicycle_sequencer;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  opcode, funct;
  logic        zero, mem_ready;
  logic [2:0]  state;
  logic        mem_req, PC_WE, IR_WE, Mem_WE, Reg_WE, A_WE, B_WE;
  logic [1:0]  PCSrc;
  logic        illegal, instr_done;
`ifdef SEQ_PERF_COUNT_EN
  logic [31:0] cycle_count, instr_count;
`endif

  always #5 clk = ~clk;

  multicycle_sequencer #(.RESET_STATE(3'd0)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready), .state(state), .mem_req(mem_req),
    .PC_WE(PC_WE), .IR_WE(IR_WE), .Mem_WE(Mem_WE), .Reg_WE(Reg_WE),
    .A_WE(A_WE), .B_WE(B_WE), .PCSrc(PCSrc), .illegal(illegal),
`ifdef SEQ_PERF_COUNT_EN
    .cycle_count(cycle_count), .instr_count(instr_count),
`endif
    .instr_done(instr_done)
  );

  // Observation word: {state, mem_req, PC_WE, IR_WE, Mem_WE, Reg_WE, A_WE, B_WE, PCSrc, illegal, instr_done}
  logic [13:0] obs;
  assign obs = {state, mem_req, PC_WE, IR_WE, Mem_WE, Reg_WE, A_WE, B_WE, PCSrc, illegal, instr_done};

  int n_vec  = 0;
  int n_err  = 0;
  int n_ticks = 0;   // rising edges since the last reset release
  int n_done  = 0;   // instructions the bench expects to have retired

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {K_ALU, K_IMM, K_LW, K_SW, K_J, K_JR, K_JAL, K_BEQ, K_BNE} kind_t;

  // Expected outputs for one cycle. The inputs are the phase the instruction
  // is in, whether the phase ends this cycle, the instruction kind and zero.
  function automatic logic [13:0] exp_out(input logic [2:0] st, input logic last,
                                          input kind_t k, input logic z);
    logic mreq, pcwe, irwe, memwe, regwe, awe, bwe, done;
    logic [1:0] src;
    mreq = 0; pcwe = 0; irwe = 0; memwe = 0; regwe = 0; awe = 0; bwe = 0; done = 0; src = 2'd0;
    case (st)
      3'd0: begin mreq = 1; if (last) begin irwe = 1; pcwe = 1; end end
      3'd1: begin
        awe = 1; bwe = 1;
        if (k == K_J) begin pcwe = 1; src = 2'd1; done = 1; end
      end
      3'd2: begin
        case (k)
          K_BEQ:   begin pcwe = z;  src = 2'd2; done = 1; end
          K_BNE:   begin pcwe = !z; src = 2'd2; done = 1; end
          K_JR:    begin pcwe = 1;  src = 2'd3; done = 1; end
          K_JAL:   begin pcwe = 1;  regwe = 1; src = 2'd1; done = 1; end
          default: ;
        endcase
      end
      3'd3: begin mreq = 1; memwe = (k == K_SW); done = last && (k == K_SW); end
      3'd4: begin regwe = 1; done = 1; end
      default: ;
    endcase
    return {st, mreq, pcwe, irwe, memwe, regwe, awe, bwe, src, 1'b0, done};
  endfunction

  task automatic pick_encoding(input kind_t k, output logic [5:0] op, output logic [5:0] fn);
    logic [5:0] alu_fn [3];
    alu_fn[0] = 6'b100000; alu_fn[1] = 6'b100010; alu_fn[2] = 6'b101010;
    fn = 6'($urandom_range(0, 63));
    case (k)
      K_ALU:   begin op = 6'b000000; fn = alu_fn[$urandom_range(0, 2)]; end
      K_IMM:   op = ($urandom_range(0, 1) != 0) ? 6'b001000 : 6'b001110;
      K_LW:    op = 6'b100011;
      K_SW:    op = 6'b101011;
      K_J:     op = 6'b000010;
      K_JR:    begin op = 6'b000000; fn = 6'b001000; end
      K_JAL:   op = 6'b000011;
      K_BEQ:   op = 6'b000100;
      default: op = 6'b000101;
    endcase
  endtask

  // ---------------- scoreboard queues ----------------
  logic [13:0] exp_q[$];
  logic        mr_q[$];
  logic        z_q[$];

  // Expands one instruction into its per-cycle expectations. The phase list
  // follows from the latency rules: J stops after ID, branches and jumps after
  // EXEC, memory ops add MEM, and writers add WB. Each stall cycle repeats
  // the phase it stalls in.
  task automatic plan_instr(input kind_t k, input int si, input int sm);
    logic [2:0] ph[$];
    logic       lst[$];
    logic       z;
    for (int i = 0; i < si; i++) begin ph.push_back(3'd0); lst.push_back(1'b0); end
    ph.push_back(3'd0); lst.push_back(1'b1);
    ph.push_back(3'd1); lst.push_back(1'b1);
    if (k != K_J) begin ph.push_back(3'd2); lst.push_back(1'b1); end
    if (k == K_LW || k == K_SW) begin
      for (int i = 0; i < sm; i++) begin ph.push_back(3'd3); lst.push_back(1'b0); end
      ph.push_back(3'd3); lst.push_back(1'b1);
    end
    if (k == K_ALU || k == K_IMM || k == K_LW) begin ph.push_back(3'd4); lst.push_back(1'b1); end
    foreach (ph[i]) begin
      z = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_out(ph[i], lst[i], k, z));
      z_q.push_back(z);
      // In a handshake phase, ready is high only in the completing cycle.
      // Elsewhere it is random and must be ignored.
      if (ph[i] == 3'd0 || ph[i] == 3'd3) mr_q.push_back(lst[i]);
      else                                mr_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- driver tasks ----------------
  // All drivers start and end at a falling edge.
  task automatic do_reset();
    reset_n   = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    #1;
    check("reset_outputs", 32'(obs), 32'd0);
`ifdef SEQ_PERF_COUNT_EN
    check("reset_cycle_count", cycle_count, 32'd0);
    check("reset_instr_count", instr_count, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    n_ticks = 0;
    n_done  = 0;
  endtask

  task automatic step_check(input string name, input logic [13:0] e);
    #1;
    check(name, 32'(obs), 32'(e));
    @(negedge clk);
    n_ticks++;
  endtask

  // Illegal instruction: IF, ID with only A/B enables, then sticky ERR.
  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn, input int err_cycles);
    opcode = op; funct = fn; zero = 1'b0;
    mem_ready = 1'b1;
    step_check("illegal_if", exp_out(3'd0, 1'b1, K_ALU, 1'b0));
    mem_ready = 1'b1;
    step_check("illegal_id", 14'b001_0000011_00_0_0);
    for (int i = 0; i < err_cycles; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      step_check("err_sticky", 14'b111_0000000_00_1_0);
    end
    do_reset();
    mem_ready = 1'b0;
    step_check("after_err_reset", exp_out(3'd0, 1'b0, K_ALU, 1'b0));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    int         si;      // IF stall cycles
    int         sm;      // MEM stall cycles
    int         cycles;  // expected cycles from entering IF to instr_done
    int         pcwe;    // expected PC_WE cycles
    int         regwe;   // expected Reg_WE cycles
    int         memwe;   // expected Mem_WE cycles
    logic [1:0] src;     // expected PCSrc in the instr_done cycle
  } vec_t;

  vec_t vecs[15];

  // ---------------- main test ----------------
  initial begin
    int cyc, acc, waited, stall, pcwe_n, regwe_n, memwe_n, done_n;
    logic [1:0] src_done;
    logic [5:0] op, fn;
    kind_t k;

    vecs[0]  = '{6'b001000, 6'd0,      1'b0, 0, 0, 4, 1, 1, 0, 2'd0}; // ADDI
    vecs[1]  = '{6'b100011, 6'd0,      1'b0, 0, 0, 5, 1, 1, 0, 2'd0}; // LW
    vecs[2]  = '{6'b101011, 6'd0,      1'b0, 0, 3, 7, 1, 0, 4, 2'd0}; // SW, 3 MEM stalls
    vecs[3]  = '{6'b000100, 6'd0,      1'b1, 0, 0, 3, 2, 0, 0, 2'd2}; // BEQ taken
    vecs[4]  = '{6'b000101, 6'd0,      1'b1, 0, 0, 3, 1, 0, 0, 2'd2}; // BNE not taken
    vecs[5]  = '{6'b000100, 6'd0,      1'b0, 0, 0, 3, 1, 0, 0, 2'd2}; // BEQ not taken
    vecs[6]  = '{6'b000101, 6'd0,      1'b0, 0, 0, 3, 2, 0, 0, 2'd2}; // BNE taken
    vecs[7]  = '{6'b000010, 6'd0,      1'b0, 0, 0, 2, 2, 0, 0, 2'd1}; // J
    vecs[8]  = '{6'b000011, 6'd0,      1'b0, 0, 0, 3, 2, 1, 0, 2'd1}; // JAL
    vecs[9]  = '{6'b000000, 6'b001000, 1'b0, 0, 0, 3, 2, 0, 0, 2'd3}; // JR
    vecs[10] = '{6'b000000, 6'b100010, 1'b0, 2, 0, 6, 1, 1, 0, 2'd0}; // SUB, 2 IF stalls
    vecs[11] = '{6'b000000, 6'b101010, 1'b1, 1, 0, 5, 1, 1, 0, 2'd0}; // SLT, 1 IF stall
    vecs[12] = '{6'b001110, 6'd0,      1'b0, 0, 0, 4, 1, 1, 0, 2'd0}; // XORI
    vecs[13] = '{6'b100011, 6'd0,      1'b0, 1, 2, 8, 1, 1, 0, 2'd0}; // LW, stalls in both
    vecs[14] = '{6'b000000, 6'b100000, 1'b0, 0, 0, 4, 1, 1, 0, 2'd0}; // ADD

    reset_n = 1'b0; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    do_reset();

    // Directed table: handshake driver responds to mem_req with planned stalls.
    for (int t = 0; t < 15; t++) begin
      opcode = vecs[t].op; funct = vecs[t].fn; zero = vecs[t].z;
      cyc = 0; acc = 0; waited = 0; pcwe_n = 0; regwe_n = 0; memwe_n = 0; done_n = 0;
      src_done = 2'd0;
      while (done_n == 0 && cyc < 40) begin
        stall = (acc == 0) ? vecs[t].si : vecs[t].sm;
        if (mem_req) begin
          mem_ready = (waited >= stall);
          if (mem_ready) begin acc++; waited = 0; end
          else waited++;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        cyc++;
        pcwe_n  += int'(PC_WE);
        regwe_n += int'(Reg_WE);
        memwe_n += int'(Mem_WE);
        if (instr_done) begin done_n++; src_done = PCSrc; end
        @(negedge clk);
        n_ticks++;
      end
      n_done++;
      check($sformatf("vec%0d_cycles", t), 32'(cyc),     32'(vecs[t].cycles));
      check($sformatf("vec%0d_pc_we", t),  32'(pcwe_n),  32'(vecs[t].pcwe));
      check($sformatf("vec%0d_reg_we", t), 32'(regwe_n), 32'(vecs[t].regwe));
      check($sformatf("vec%0d_mem_we", t), 32'(memwe_n), 32'(vecs[t].memwe));
      check($sformatf("vec%0d_pcsrc", t),  32'(src_done), 32'(vecs[t].src));
      check($sformatf("vec%0d_state", t),  32'(state),   32'd0);
    end

    // Randomized instruction stream against the per-cycle model.
    for (int n = 0; n < 200; n++) begin
      k = kind_t'($urandom_range(0, 8));
      pick_encoding(k, op, fn);
      opcode = op; funct = fn;
      plan_instr(k, $urandom_range(0, 3), $urandom_range(0, 3));
      while (exp_q.size() > 0) begin
        mem_ready = mr_q.pop_front();
        zero      = z_q.pop_front();
        step_check("rand_cycle", exp_q.pop_front());
      end
      n_done++;
    end

`ifdef SEQ_PERF_COUNT_EN
    check("cycle_count", cycle_count, 32'(n_ticks));
    check("instr_count", instr_count, 32'(n_done));
`endif

    // Illegal opcode and illegal R-type funct both trap into sticky ERR.
    run_illegal(6'b111111, 6'd0, 10);
    run_illegal(6'b000000, 6'b000001, 3);

    // Reset in the middle of a stalled SW: Mem_WE must drop without an edge.
    opcode = 6'b101011; funct = 6'd0; zero = 1'b0;
    mem_ready = 1'b1;
    step_check("sw_if", exp_out(3'd0, 1'b1, K_SW, 1'b0));
    mem_ready = 1'b0;
    step_check("sw_id", exp_out(3'd1, 1'b1, K_SW, 1'b0));
    step_check("sw_exec", exp_out(3'd2, 1'b1, K_SW, 1'b0));
    #1;
    check("sw_mem_stall", 32'(obs), 32'(exp_out(3'd3, 1'b0, K_SW, 1'b0)));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_mem_we", 32'(Mem_WE), 32'd0);
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_mem_req", 32'(mem_req), 32'd0);
`ifdef SEQ_PERF_COUNT_EN
    check("async_reset_cycle_count", cycle_count, 32'd0);
    check("async_reset_instr_count", instr_count, 32'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
